mem_access_arbiter: RTL and testbench
=====================================

Name: mem_access_arbiter

Overview:
- Shares the single memory port between two requesters:
  - the instruction-fetch port (IF, read-only);
  - the data-memory port (DM), driven by the alu_mem address/data outputs for LOAD/STORE.
- Captures one request, presents it on the memory bus, waits for the response and routes it back to the owner.
- Sits between the core datapath and the memory model/controller.
- Allows exactly one outstanding transaction.

Parameters:
- ADDR_WIDTH, 32, width of all address buses
- DATA_WIDTH, 32, width of all data buses
- CNT_WIDTH, 16, width of the saturating completion counters

Ports:
- clk_i  in  1  system clock, rising edge
- arst_ni  in  1  asynchronous active-low reset
- if_req_i  in  1  IF read request
- if_addr_i  in  ADDR_WIDTH  IF address
- if_gnt_o  out  1  IF request captured (1-cycle pulse)
- if_rvalid_o  out  1  IF read data valid (1-cycle pulse)
- if_rdata_o  out  DATA_WIDTH  IF read data
- dm_req_i  in  1  DM request
- dm_we_i  in  1  DM write enable (1 = STORE, 0 = LOAD)
- dm_addr_i  in  ADDR_WIDTH  DM address
- dm_wdata_i  in  DATA_WIDTH  DM store data
- dm_gnt_o  out  1  DM request captured (1-cycle pulse)
- dm_rvalid_o  out  1  DM response valid (1-cycle pulse; pulses for both LOAD and STORE)
- dm_rdata_o  out  DATA_WIDTH  DM load data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid; returned for writes too
- mem_rdata_i  in  DATA_WIDTH  memory read data
- if_cnt_o  out  CNT_WIDTH  completed IF transactions, saturating
- dm_cnt_o  out  CNT_WIDTH  completed DM transactions, saturating

Behaviour:
- Reset, asynchronous on arst_ni low:
  - state = IDLE, owner = IF, last_owner = IF.
  - All outputs 0, both counters 0.
  - Any in-flight transaction is dropped; late mem_rvalid_i is ignored because state is IDLE.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If any req_i is high, pick the winner:
    - Only one requesting: that one wins.
    - Both requesting: the one not equal to last_owner wins. Out of reset last_owner = IF, so DM wins the first tie.
  - On the capture cycle (combinational): pulse the winner's gnt_o. Registered at the edge: we/addr/wdata (IF: we = 0, wdata = 0), owner, last_owner <= owner, state -> REQ.
  - The requester may drop or change req_i after seeing its gnt_o.
- REQ:
  - mem_req_o = 1; mem_we_o/addr/wdata driven from the capture registers and held stable until mem_gnt_i.
  - When mem_gnt_i = 1: state -> RESP; mem_req_o deasserts the following cycle.
  - mem_rvalid_i in REQ is ignored.
- RESP:
  - mem_req_o = 0.
  - When mem_rvalid_i = 1 (combinational same-cycle routing):
    - owner's rvalid_o = 1, owner's rdata_o = mem_rdata_i;
    - owner's counter += 1, saturating at all-ones;
    - state -> IDLE.
- Non-owner rvalid_o is always 0.
- rdata_o of both ports = mem_rdata_i when that port's rvalid_o is high, else 0.
- No gnt_o in REQ or RESP: requesters hold req_i and wait.
- Minimum latency:
  - request at cycle 0 (gnt_o pulse);
  - mem_req_o at cycle 1; mem_gnt_i at cycle 1 gives RESP at cycle 2;
  - rvalid_o as early as cycle 2;
  - next capture in IDLE at cycle 3.
- Sustained throughput: one transaction per 3 cycles.
- Fairness: under continuous contention grants alternate IF, DM, IF, DM…; a sole requester is granted back-to-back.
- mem_* are registered outputs. gnt_o and rvalid_o/rdata_o are combinational from state and inputs.

Test Plan:
- Reset then idle, no requests for 10 cycles:
  - all outputs 0, counters 0;
  - mem_rvalid_i = 1 injected in IDLE produces no rvalid_o.
- DM LOAD alone (dm_addr_i = 0x100, we = 0), mem_gnt_i at cycle 1, mem_rvalid_i at cycle 2 with rdata 0xDEADBEEF:
  - dm_gnt_o at cycle 0;
  - mem_addr_o = 0x100, mem_we_o = 0 at cycle 1;
  - dm_rvalid_o and dm_rdata_o = 0xDEADBEEF at cycle 2;
  - dm_cnt_o = 1.
- DM STORE (addr 0x40, wdata 0x12345678) with mem_gnt_i delayed 4 cycles:
  - mem_req_o/addr/wdata held stable for all 4 stall cycles;
  - dm_rvalid_o pulses on mem_rvalid_i.
- Both requesting continuously for 6 transactions, memory zero-wait:
  - grant order DM, IF, DM, IF, DM, IF;
  - if_cnt_o = 3, dm_cnt_o = 3;
  - if_rvalid_o never coincides with a DM-owned response.
- arst_ni pulsed low while in RESP:
  - outputs 0 immediately;
  - subsequent mem_rvalid_i is ignored;
  - the next request is served normally.
- CNT_WIDTH = 4 with 20 IF reads: if_cnt_o saturates at 15.

Source files
------------

// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_arbiter
//  Description : Shares one memory port between the instruction-fetch port
//                (IF, read-only) and the data-memory port (DM, LOAD/STORE).
//                One request is captured, presented on the memory bus, and
//                the response is routed back to the owner. Exactly one
//                transaction may be outstanding at any time.
//  Ports       :
//      clk_i, arst_ni                 clock / async active-low reset
//      if_req_i, if_addr_i            IF read request
//      if_gnt_o, if_rvalid_o,
//      if_rdata_o                     IF grant pulse / response
//      dm_req_i, dm_we_i, dm_addr_i,
//      dm_wdata_i                     DM request
//      dm_gnt_o, dm_rvalid_o,
//      dm_rdata_o                     DM grant pulse / response
//      mem_req_o, mem_we_o,
//      mem_addr_o, mem_wdata_o        registered memory request
//      mem_gnt_i, mem_rvalid_i,
//      mem_rdata_i                    memory handshake / response
//      if_cnt_o, dm_cnt_o             saturating completion counters
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [DATA_WIDTH-1:0] dm_wdata_i,
    output logic                  dm_gnt_o,
    output logic                  dm_rvalid_o,
    output logic [DATA_WIDTH-1:0] dm_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [CNT_WIDTH-1:0]  if_cnt_o,
    output logic [CNT_WIDTH-1:0]  dm_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [CNT_WIDTH-1:0]  if_cnt_q, if_cnt_d;
    logic [CNT_WIDTH-1:0]  dm_cnt_q, dm_cnt_d;
    logic                  winner;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_cnt_d     = if_cnt_q;
        dm_cnt_d     = dm_cnt_q;
        winner       = OWNER_IF;
        if_gnt_o     = 1'b0;
        dm_gnt_o     = 1'b0;
        if_rvalid_o  = 1'b0;
        dm_rvalid_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (if_req_i || dm_req_i) begin
                    // On a tie the port that did not win last time goes next,
                    // giving strict alternation under sustained contention.
                    if (if_req_i && dm_req_i) begin
                        winner = ~last_owner_q;
                    end else begin
                        winner = dm_req_i ? OWNER_DM : OWNER_IF;
                    end
                    owner_d      = winner;
                    last_owner_d = winner;
                    mem_req_d    = 1'b1;
                    state_d      = ST_REQ;
                    if (winner == OWNER_DM) begin
                        dm_gnt_o    = 1'b1;
                        mem_we_d    = dm_we_i;
                        mem_addr_d  = dm_addr_i;
                        mem_wdata_d = dm_wdata_i;
                    end else begin
                        if_gnt_o    = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                    end
                end
            end
            ST_REQ: begin
                // Request lines stay frozen until the memory accepts.
                if (mem_gnt_i) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_rvalid_i) begin
                    state_d = ST_IDLE;
                    if (owner_q == OWNER_DM) begin
                        dm_rvalid_o = 1'b1;
                        if (dm_cnt_q != '1) dm_cnt_d = dm_cnt_q + CNT_ONE;
                    end else begin
                        if_rvalid_o = 1'b1;
                        if (if_cnt_q != '1) if_cnt_d = if_cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_IF;
            last_owner_q <= OWNER_IF;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_cnt_q     <= '0;
            dm_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_cnt_q     <= if_cnt_d;
            dm_cnt_q     <= dm_cnt_d;
        end
    end

    // Read data is gated so the idle port never sees memory traffic.
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_cnt_o    = if_cnt_q;
    assign dm_cnt_o    = dm_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_arbiter
//  Description : Directed self-checking bench for mem_access_arbiter. Inputs
//                change on the falling edge; outputs are sampled 1 time unit
//                later, well away from the rising (active) edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CNT_W = 4;

    logic          clk_i = 1'b0;
    logic          arst_ni;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o, if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          dm_req_i, dm_we_i;
    logic [AW-1:0] dm_addr_i;
    logic [DW-1:0] dm_wdata_i;
    logic          dm_gnt_o, dm_rvalid_o;
    logic [DW-1:0] dm_rdata_o;
    logic          mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i, mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic [CNT_W-1:0] if_cnt_o, dm_cnt_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    mem_access_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CNT_W)
    ) dut (
        .clk_i        (clk_i),
        .arst_ni      (arst_ni),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .dm_req_i     (dm_req_i),
        .dm_we_i      (dm_we_i),
        .dm_addr_i    (dm_addr_i),
        .dm_wdata_i   (dm_wdata_i),
        .dm_gnt_o     (dm_gnt_o),
        .dm_rvalid_o  (dm_rvalid_o),
        .dm_rdata_o   (dm_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .if_cnt_o     (if_cnt_o),
        .dm_cnt_o     (dm_cnt_o)
    );

    task automatic clear_inputs();
        if_req_i     = 1'b0;
        if_addr_i    = '0;
        dm_req_i     = 1'b0;
        dm_we_i      = 1'b0;
        dm_addr_i    = '0;
        dm_wdata_i   = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        arst_ni = 1'b0;
        @(negedge clk_i);
        arst_ni = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        clear_inputs();
        arst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        arst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            flags = {if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o, mem_req_o, mem_we_o, 2'b00};
            checks++;
            if (flags !== 8'h00) begin
                errors++;
                $display("FAIL reset_idle_flags cycle %0d: got %b want 00000000", i, flags);
            end
            checks++;
            if ({mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o} !== '0 ||
                if_cnt_o !== '0 || dm_cnt_o !== '0) begin
                errors++;
                $display("FAIL reset_idle_buses cycle %0d: addr=%h wdata=%h ifcnt=%0d dmcnt=%0d want all 0",
                         i, mem_addr_o, mem_wdata_o, if_cnt_o, dm_cnt_o);
            end
            @(negedge clk_i);
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h5555_AAAA;
        #1;
        checks++;
        if ({if_rvalid_o, dm_rvalid_o} !== 2'b00 || if_rdata_o !== '0 || dm_rdata_o !== '0) begin
            errors++;
            $display("FAIL idle_rvalid_ignored: if_rv=%b dm_rv=%b want 0 0", if_rvalid_o, dm_rvalid_o);
        end
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || if_cnt_o !== '0 || dm_cnt_o !== '0) begin
            errors++;
            $display("FAIL idle_after_rvalid: mem_req=%b ifcnt=%0d dmcnt=%0d want 0 0 0",
                     mem_req_o, if_cnt_o, dm_cnt_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_dm_load();
        dm_req_i  = 1'b1;
        dm_we_i   = 1'b0;
        dm_addr_i = 32'h100;
        #1;
        checks++;
        if (dm_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL load_gnt: dm_gnt=%b if_gnt=%b want 1 0", dm_gnt_o, if_gnt_o);
        end
        @(negedge clk_i);
        dm_req_i  = 1'b0;
        mem_gnt_i = 1'b1;
        #1;
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL load_mem_req: req=%b addr=%h we=%b want 1 00000100 0", mem_req_o, mem_addr_o, mem_we_o);
        end
        @(negedge clk_i);
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (dm_rvalid_o !== 1'b1 || dm_rdata_o !== 32'hDEAD_BEEF || if_rvalid_o !== 1'b0 ||
            if_rdata_o !== '0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL load_resp: dm_rv=%b dm_rdata=%h if_rv=%b mem_req=%b want 1 deadbeef 0 0",
                     dm_rvalid_o, dm_rdata_o, if_rvalid_o, mem_req_o);
        end
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        #1;
        checks++;
        if (dm_cnt_o !== 4'd1 || if_cnt_o !== 4'd0 || dm_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL load_cnt: dmcnt=%0d ifcnt=%0d dm_rv=%b want 1 0 0", dm_cnt_o, if_cnt_o, dm_rvalid_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_dm_store_stall();
        dm_req_i   = 1'b1;
        dm_we_i    = 1'b1;
        dm_addr_i  = 32'h40;
        dm_wdata_i = 32'h1234_5678;
        #1;
        checks++;
        if (dm_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL store_gnt: dm_gnt=%b want 1", dm_gnt_o);
        end
        @(negedge clk_i);
        // Requester changes its lines after the grant; the bus must not follow.
        dm_req_i   = 1'b0;
        dm_we_i    = 1'b0;
        dm_addr_i  = 32'hFFFF_0000;
        dm_wdata_i = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            mem_gnt_i = (i == 4);
            #1;
            checks++;
            if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h40 ||
                mem_wdata_o !== 32'h1234_5678 || dm_rvalid_o !== 1'b0) begin
                errors++;
                $display("FAIL store_stall cycle %0d: req=%b we=%b addr=%h wdata=%h dm_rv=%b want 1 1 00000040 12345678 0",
                         i, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, dm_rvalid_o);
            end
            @(negedge clk_i);
        end
        mem_gnt_i = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || dm_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL store_wait_resp: req=%b dm_rv=%b want 0 0", mem_req_o, dm_rvalid_o);
        end
        @(negedge clk_i);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_00AB;
        #1;
        checks++;
        if (dm_rvalid_o !== 1'b1 || dm_rdata_o !== 32'h0000_00AB || if_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL store_resp: dm_rv=%b dm_rdata=%h if_rv=%b want 1 000000ab 0",
                     dm_rvalid_o, dm_rdata_o, if_rvalid_o);
        end
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        #1;
        checks++;
        if (dm_cnt_o !== 4'd2) begin
            errors++;
            $display("FAIL store_cnt: dmcnt=%0d want 2", dm_cnt_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_contention();
        int  k;
        int  p;
        logic exp_dm;
        do_reset();
        if_req_i     = 1'b1;
        if_addr_i    = 32'h200;
        dm_req_i     = 1'b1;
        dm_we_i      = 1'b0;
        dm_addr_i    = 32'h300;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        for (int c = 0; c < 18; c++) begin
            k = c / 3;
            p = c % 3;
            exp_dm = (k % 2 == 0);
            mem_rdata_i = 32'hC000_0000 + k;
            #1;
            checks++;
            if (p == 0) begin
                if (dm_gnt_o !== exp_dm || if_gnt_o !== !exp_dm || if_rvalid_o || dm_rvalid_o) begin
                    errors++;
                    $display("FAIL contention_gnt txn %0d: dm_gnt=%b if_gnt=%b want %b %b",
                             k, dm_gnt_o, if_gnt_o, exp_dm, !exp_dm);
                end
            end else if (p == 1) begin
                if (mem_req_o !== 1'b1 || mem_addr_o !== (exp_dm ? 32'h300 : 32'h200) ||
                    if_gnt_o || dm_gnt_o) begin
                    errors++;
                    $display("FAIL contention_req txn %0d: req=%b addr=%h gnts=%b%b want 1 %h 00",
                             k, mem_req_o, mem_addr_o, if_gnt_o, dm_gnt_o, exp_dm ? 32'h300 : 32'h200);
                end
            end else begin
                if (dm_rvalid_o !== exp_dm || if_rvalid_o !== !exp_dm ||
                    (exp_dm ? dm_rdata_o : if_rdata_o) !== 32'hC000_0000 + k ||
                    (exp_dm ? if_rdata_o : dm_rdata_o) !== '0) begin
                    errors++;
                    $display("FAIL contention_resp txn %0d: dm_rv=%b if_rv=%b dm_rd=%h if_rd=%h want dm_rv=%b",
                             k, dm_rvalid_o, if_rvalid_o, dm_rdata_o, if_rdata_o, exp_dm);
                end
            end
            @(negedge clk_i);
        end
        clear_inputs();
        #1;
        checks++;
        if (if_cnt_o !== 4'd3 || dm_cnt_o !== 4'd3) begin
            errors++;
            $display("FAIL contention_cnt: ifcnt=%0d dmcnt=%0d want 3 3", if_cnt_o, dm_cnt_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset_in_resp();
        if_req_i  = 1'b1;
        if_addr_i = 32'h500;
        #1;
        checks++;
        if (if_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL rir_gnt: if_gnt=%b want 1", if_gnt_o);
        end
        @(negedge clk_i);
        if_req_i  = 1'b0;
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0;
        arst_ni   = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== '0 || if_cnt_o !== '0 || dm_cnt_o !== '0 ||
            if_gnt_o || dm_gnt_o || if_rvalid_o || dm_rvalid_o) begin
            errors++;
            $display("FAIL rir_async_clear: req=%b addr=%h ifcnt=%0d dmcnt=%0d want 0 0 0 0",
                     mem_req_o, mem_addr_o, if_cnt_o, dm_cnt_o);
        end
        @(negedge clk_i);
        arst_ni      = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h77;
        #1;
        checks++;
        if (if_rvalid_o !== 1'b0 || dm_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL rir_late_rvalid: if_rv=%b dm_rv=%b want 0 0", if_rvalid_o, dm_rvalid_o);
        end
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || if_cnt_o !== '0) begin
            errors++;
            $display("FAIL rir_still_idle: req=%b ifcnt=%0d want 0 0", mem_req_o, if_cnt_o);
        end
        if_req_i  = 1'b1;
        if_addr_i = 32'h600;
        #1;
        checks++;
        if (if_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL rir_new_gnt: if_gnt=%b want 1", if_gnt_o);
        end
        @(negedge clk_i);
        if_req_i  = 1'b0;
        mem_gnt_i = 1'b1;
        #1;
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h600 || mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL rir_new_req: req=%b addr=%h we=%b want 1 00000600 0", mem_req_o, mem_addr_o, mem_we_o);
        end
        @(negedge clk_i);
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h600D;
        #1;
        checks++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h600D || dm_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL rir_new_resp: if_rv=%b if_rdata=%h dm_rv=%b want 1 0000600d 0",
                     if_rvalid_o, if_rdata_o, dm_rvalid_o);
        end
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        #1;
        checks++;
        if (if_cnt_o !== 4'd1) begin
            errors++;
            $display("FAIL rir_cnt: ifcnt=%0d want 1", if_cnt_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_saturation();
        int p;
        do_reset();
        if_req_i     = 1'b1;
        if_addr_i    = 32'h80;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        for (int c = 0; c < 60; c++) begin
            p = c % 3;
            mem_rdata_i = 32'hA000 + c;
            #1;
            if (c == 45) begin
                checks++;
                if (if_cnt_o !== 4'd15) begin
                    errors++;
                    $display("FAIL sat_reach15: ifcnt=%0d want 15", if_cnt_o);
                end
            end
            if (p == 0) begin
                checks++;
                if (if_gnt_o !== 1'b1 || dm_gnt_o !== 1'b0) begin
                    errors++;
                    $display("FAIL sat_b2b_gnt txn %0d: if_gnt=%b dm_gnt=%b want 1 0", c / 3, if_gnt_o, dm_gnt_o);
                end
            end else if (p == 2) begin
                checks++;
                if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hA000 + c) begin
                    errors++;
                    $display("FAIL sat_resp txn %0d: if_rv=%b if_rdata=%h want 1 %h",
                             c / 3, if_rvalid_o, if_rdata_o, 32'hA000 + c);
                end
            end
            @(negedge clk_i);
        end
        clear_inputs();
        #1;
        checks++;
        if (if_cnt_o !== 4'd15 || dm_cnt_o !== 4'd0) begin
            errors++;
            $display("FAIL sat_final: ifcnt=%0d dmcnt=%0d want 15 0", if_cnt_o, dm_cnt_o);
        end
        @(negedge clk_i);
    endtask

    initial begin
        clear_inputs();
        arst_ni = 1'b0;
        test_reset();
        test_dm_load();
        test_dm_store_stall();
        test_contention();
        test_reset_in_resp();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
